// File: rtl/turfio_cin_parallel_lock.sv
// ---------------------------------------------------------------------------
// turfio_cin_parallel_lock
//
// Deserialises NLANE independent CIN lanes into WORD_BITS-wide parallel words
// and finds the word phase of each lane automatically. Alignment uses a known
// training word: each lane slips its word boundary by one beat at a time until
// the assembled word equals TRAIN_PATTERN. The lane declares lock once it has
// seen LOCK_COUNT consecutive matching words.
//
// Ports:
//   aclk_i               - the only clock
//   aresetn_i            - async-assert, active-low reset (release synchronised)
//   cin_i                - lane n occupies [n*INBITS +: INBITS]
//   cin_valid_i          - beat qualifier shared by all lanes
//   lock_i               - pulse: (re)start automatic alignment on all lanes
//   lock_rst_i           - pulse: abort/unlock all lanes, back to IDLE
//   bitslip_i            - pulse per lane: manual word-phase slip (IDLE only)
//   capture_i            - pulse: snapshot cin_parallel_o into capture_data_o
//   locked_o             - lane is LOCKED
//   lock_fail_o          - lane ran out of slips without a match (sticky)
//   cin_biterr_o         - pulse: training mismatch while verifying
//   cin_parallel_o       - last assembled word per lane
//   cin_parallel_valid_o - per-lane word strobe, only while LOCKED
//   capture_data_o       - snapshot register
// ---------------------------------------------------------------------------
module turfio_cin_parallel_lock #(
    parameter int                   NLANE         = 1,
    parameter int                   INBITS        = 4,
    parameter int                   WORD_BITS     = 32,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter int                   LOCK_COUNT    = 4
) (
    input  logic                       aclk_i,
    input  logic                       aresetn_i,
    input  logic [NLANE*INBITS-1:0]    cin_i,
    input  logic                       cin_valid_i,
    input  logic                       lock_i,
    input  logic                       lock_rst_i,
    input  logic [NLANE-1:0]           bitslip_i,
    input  logic                       capture_i,
    output logic [NLANE-1:0]           locked_o,
    output logic [NLANE-1:0]           lock_fail_o,
    output logic [NLANE-1:0]           cin_biterr_o,
    output logic [NLANE*WORD_BITS-1:0] cin_parallel_o,
    output logic [NLANE-1:0]           cin_parallel_valid_o,
    output logic [NLANE*WORD_BITS-1:0] capture_data_o
);

    localparam int NBEATS = WORD_BITS / INBITS;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SLIP_W = $clog2(NBEATS + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NBEATS - 1);
    localparam logic [SLIP_W-1:0] LAST_SLIP  = SLIP_W'(NBEATS - 1);
    localparam logic [7:0]        LAST_MATCH = 8'(LOCK_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED,
        ST_FAIL
    } lane_state_t;

    // Reset synchroniser: assertion reaches the core immediately through the
    // async clear, release is delayed two clocks so it is clean w.r.t. aclk_i.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    for (genvar n = 0; n < NLANE; n++) begin : g_lane

        logic [INBITS-1:0]    beat;
        logic [WORD_BITS-1:0] shift_q;
        logic [WORD_BITS-1:0] shift_next;
        logic [BEAT_W-1:0]    beat_cnt;
        logic                 slip_pending;
        logic                 slip_req;
        logic                 boundary;
        logic                 is_match;
        logic [WORD_BITS-1:0] par_q;

        lane_state_t          state;
        logic [SLIP_W-1:0]    slip_cnt;
        logic [7:0]           match_cnt;
        logic                 settle;
        logic                 locked_q;
        logic                 fail_q;
        logic                 biterr_q;
        logic                 pvalid_q;

        assign beat       = cin_i[n*INBITS +: INBITS];
        assign shift_next = {shift_q[WORD_BITS-INBITS-1:0], beat};

        // A pending slip suppresses the boundary on the beat where the counter
        // is held, so the boundary moves one beat later.
        assign boundary = cin_valid_i && !slip_pending && (beat_cnt == LAST_BEAT);
        assign is_match = (shift_next == TRAIN_PATTERN);

        // Slip sources: manual request in IDLE, or a counted mismatch in HUNT.
        // lock_i / lock_rst_i take priority over any state activity.
        always_comb begin
            slip_req = 1'b0;
            if (!lock_rst_i && !lock_i) begin
                case (state)
                    ST_IDLE: slip_req = bitslip_i[n];
                    ST_HUNT: slip_req = boundary && !settle && !is_match;
                    default: slip_req = 1'b0;
                endcase
            end
        end

        // Datapath: shift register, beat counter, slip holding and word output.
        // A slip raised on a boundary only takes effect from the next beat, so
        // the boundary word itself is still registered.
        always_ff @(posedge aclk_i or negedge rst_n) begin
            if (!rst_n) begin
                shift_q      <= '0;
                beat_cnt     <= '0;
                slip_pending <= 1'b0;
                par_q        <= '0;
            end else begin
                if (cin_valid_i) begin
                    shift_q <= shift_next;
                end
                if (cin_valid_i && !slip_pending) begin
                    beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
                end
                if (slip_req && !slip_pending) begin
                    slip_pending <= 1'b1;
                end else if (cin_valid_i) begin
                    slip_pending <= 1'b0;
                end
                if (boundary) begin
                    par_q <= shift_next;
                end
            end
        end

        // Alignment FSM with registered flag outputs. After a HUNT slip the next
        // word is not compared, giving the new phase one word to settle.
        always_ff @(posedge aclk_i or negedge rst_n) begin
            if (!rst_n) begin
                state     <= ST_IDLE;
                slip_cnt  <= '0;
                match_cnt <= '0;
                settle    <= 1'b0;
                locked_q  <= 1'b0;
                fail_q    <= 1'b0;
                biterr_q  <= 1'b0;
                pvalid_q  <= 1'b0;
            end else begin
                biterr_q <= 1'b0;
                pvalid_q <= boundary && (state == ST_LOCKED);

                if (lock_rst_i) begin
                    state     <= ST_IDLE;
                    slip_cnt  <= '0;
                    match_cnt <= '0;
                    settle    <= 1'b0;
                    locked_q  <= 1'b0;
                    fail_q    <= 1'b0;
                end else if (lock_i) begin
                    state     <= ST_HUNT;
                    slip_cnt  <= '0;
                    match_cnt <= '0;
                    settle    <= 1'b0;
                    locked_q  <= 1'b0;
                    fail_q    <= 1'b0;
                end else begin
                    case (state)
                        ST_HUNT: begin
                            if (boundary) begin
                                if (settle) begin
                                    settle <= 1'b0;
                                end else if (is_match) begin
                                    match_cnt <= 8'd1;
                                    if (LOCK_COUNT == 1) begin
                                        state    <= ST_LOCKED;
                                        locked_q <= 1'b1;
                                    end else begin
                                        state <= ST_VERIFY;
                                    end
                                end else begin
                                    slip_cnt <= slip_cnt + SLIP_W'(1);
                                    settle   <= 1'b1;
                                    if (slip_cnt == LAST_SLIP) begin
                                        state  <= ST_FAIL;
                                        fail_q <= 1'b1;
                                    end
                                end
                            end
                        end
                        ST_VERIFY: begin
                            if (boundary) begin
                                if (is_match) begin
                                    match_cnt <= match_cnt + 8'd1;
                                    if (match_cnt == LAST_MATCH) begin
                                        state    <= ST_LOCKED;
                                        locked_q <= 1'b1;
                                    end
                                end else begin
                                    biterr_q  <= 1'b1;
                                    match_cnt <= '0;
                                    state     <= ST_HUNT;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign locked_o[n]                                 = locked_q;
        assign lock_fail_o[n]                              = fail_q;
        assign cin_biterr_o[n]                             = biterr_q;
        assign cin_parallel_valid_o[n]                     = pvalid_q;
        assign cin_parallel_o[n*WORD_BITS +: WORD_BITS]    = par_q;
    end

    // Snapshot of every lane's last word, regardless of lane state.
    always_ff @(posedge aclk_i or negedge rst_n) begin
        if (!rst_n) begin
            capture_data_o <= '0;
        end else if (capture_i) begin
            capture_data_o <= cin_parallel_o;
        end
    end

endmodule

// File: tb/tb_turfio_cin_parallel_lock.sv
// ---------------------------------------------------------------------------
// tb_turfio_cin_parallel_lock
//
// Bench for turfio_cin_parallel_lock. A single-lane instance runs a table of
// alignment scenarios (nibble offset / dead stream with hand-computed lock and
// fail beats), then hand-written sequences for manual slip, verify errors,
// async reset with capture. A two-lane instance checks independent locking
// with a gapped valid.
//
// Beat timing used for the expected values (cin_valid_i always 1, lock_i
// before the first beat, beat 0 is the first valid beat after reset):
//   first boundary at beat 7; a HUNT slip moves the next boundary 9 beats
//   later and that word is skipped, so k slips put the first match at
//   7 + 17k and lock at 7 + 17k + 8*(LOCK_COUNT-1).
// ---------------------------------------------------------------------------
module tb_turfio_cin_parallel_lock;

    localparam logic [31:0] PAT = 32'hA55A6996;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // single-lane DUT
    logic        aresetn   = 1'b0;
    logic [3:0]  cin       = '0;
    logic        cin_valid = 1'b0;
    logic        lock      = 1'b0;
    logic        lock_rst  = 1'b0;
    logic [0:0]  bitslip   = '0;
    logic        capture   = 1'b0;
    logic [0:0]  locked;
    logic [0:0]  lock_fail;
    logic [0:0]  biterr;
    logic [31:0] par;
    logic [0:0]  pvalid;
    logic [31:0] cap;

    // two-lane DUT
    logic        aresetn2  = 1'b0;
    logic [7:0]  cin2      = '0;
    logic        valid2    = 1'b0;
    logic        lock2     = 1'b0;
    logic        lock_rst2 = 1'b0;
    logic [1:0]  bitslip2  = '0;
    logic        capture2  = 1'b0;
    logic [1:0]  locked2;
    logic [1:0]  fail2;
    logic [1:0]  biterr2;
    logic [63:0] par2;
    logic [1:0]  pvalid2;
    logic [63:0] cap2;

    turfio_cin_parallel_lock dut (
        .aclk_i               (aclk),
        .aresetn_i            (aresetn),
        .cin_i                (cin),
        .cin_valid_i          (cin_valid),
        .lock_i               (lock),
        .lock_rst_i           (lock_rst),
        .bitslip_i            (bitslip),
        .capture_i            (capture),
        .locked_o             (locked),
        .lock_fail_o          (lock_fail),
        .cin_biterr_o         (biterr),
        .cin_parallel_o       (par),
        .cin_parallel_valid_o (pvalid),
        .capture_data_o       (cap)
    );

    turfio_cin_parallel_lock #(.NLANE(2)) dut2 (
        .aclk_i               (aclk),
        .aresetn_i            (aresetn2),
        .cin_i                (cin2),
        .cin_valid_i          (valid2),
        .lock_i               (lock2),
        .lock_rst_i           (lock_rst2),
        .bitslip_i            (bitslip2),
        .capture_i            (capture2),
        .locked_o             (locked2),
        .lock_fail_o          (fail2),
        .cin_biterr_o         (biterr2),
        .cin_parallel_o       (par2),
        .cin_parallel_valid_o (pvalid2),
        .capture_data_o       (cap2)
    );

    typedef struct {
        int offset;
        bit zero_stream;
        int exp_lock;
        int exp_fail;
        int exp_first_word;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_fail   = 0;

    int lock_beat, fail_beat, first_word, biterr_cnt, biterr_beat;
    int bad_words, pvalid_cnt, locked_cycles;
    int lockc[2], pcnt[2], lastp[2], bad_gap, bad_word2, biterr2_cnt;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    function automatic logic [3:0] patNib(input int idx);
        logic [31:0] p;
        p = PAT;
        return p[31-4*idx -: 4];
    endfunction

    function automatic logic [3:0] streamNib(input int b, input int off);
        return patNib(((b - off) % 8 + 8) % 8);
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] nib, input logic vld);
        cin       = nib;
        cin_valid = vld;
        step();
    endtask

    task automatic resetDut();
        aresetn   = 1'b0;
        cin_valid = 1'b0;
        cin       = '0;
        lock      = 1'b0;
        lock_rst  = 1'b0;
        bitslip   = '0;
        capture   = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        repeat (4) step();
    endtask

    task automatic pulseLock();
        lock = 1'b1;
        applyStimulus(4'h0, 1'b0);
        lock = 1'b0;
    endtask

    task automatic clearStats();
        lock_beat   = -1;
        fail_beat   = -1;
        first_word  = -1;
        biterr_cnt  = 0;
        biterr_beat = -1;
        bad_words   = 0;
        pvalid_cnt  = 0;
    endtask

    task automatic sampleLane(input int i);
        if (locked[0] && lock_beat < 0) lock_beat = i;
        if (lock_fail[0] && fail_beat < 0) fail_beat = i;
        if (biterr[0]) begin
            biterr_cnt++;
            if (biterr_beat < 0) biterr_beat = i;
        end
        if (pvalid[0]) begin
            pvalid_cnt++;
            if (first_word < 0) first_word = i;
            if (par !== PAT) bad_words++;
        end
    endtask

    initial begin
        vecs[0] = '{0, 1'b0,  31, -1,  39};
        vecs[1] = '{3, 1'b0,  82, -1,  90};
        vecs[2] = '{1, 1'b0,  48, -1,  56};
        vecs[3] = '{7, 1'b0, 150, -1, 158};
        vecs[4] = '{0, 1'b1,  -1, 126, -1};

        // reset state
        resetDut();
        checkOutput("reset locked", 64'(locked), 64'(0));
        checkOutput("reset par", 64'(par), 64'(0));
        checkOutput("reset cap", 64'(cap), 64'(0));

        // table of alignment scenarios
        for (int v = 0; v < 5; v++) begin
            resetDut();
            pulseLock();
            clearStats();
            for (int i = 0; i < 200; i++) begin
                applyStimulus(vecs[v].zero_stream ? 4'h0 : streamNib(i, vecs[v].offset), 1'b1);
                sampleLane(i);
            end
            checkOutput($sformatf("vec%0d lock_beat", v), 64'(lock_beat), 64'(vecs[v].exp_lock));
            checkOutput($sformatf("vec%0d fail_beat", v), 64'(fail_beat), 64'(vecs[v].exp_fail));
            checkOutput($sformatf("vec%0d first_word_beat", v), 64'(first_word), 64'(vecs[v].exp_first_word));
            checkOutput($sformatf("vec%0d biterr_cnt", v), 64'(biterr_cnt), 64'(0));
            checkOutput($sformatf("vec%0d bad_words", v), 64'(bad_words), 64'(0));
            lock_rst = 1'b1;
            applyStimulus(4'h0, 1'b0);
            lock_rst = 1'b0;
            checkOutput($sformatf("vec%0d locked after lock_rst", v), 64'(locked), 64'(0));
            checkOutput($sformatf("vec%0d lock_fail after lock_rst", v), 64'(lock_fail), 64'(0));
        end

        // manual slip in IDLE; second request while pending is dropped
        resetDut();
        bitslip = 1'b1;
        applyStimulus(4'h0, 1'b0);
        applyStimulus(4'h0, 1'b0);
        bitslip = 1'b0;
        clearStats();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(streamNib(i, 0), 1'b1);
            sampleLane(i);
            if (i == 7) checkOutput("slip par@7", 64'(par), 64'(0));
            if (i == 8) checkOutput("slip par@8", 64'(par), 64'(32'h55A6996A));
        end
        checkOutput("idle pvalid_cnt", 64'(pvalid_cnt), 64'(0));

        // corrupted word in VERIFY, bitslip ignored in LOCKED
        resetDut();
        pulseLock();
        clearStats();
        for (int i = 0; i < 80; i++) begin
            if (i == 50) bitslip = 1'b1;
            applyStimulus(streamNib(i, 0) ^ ((i == 10) ? 4'h1 : 4'h0), 1'b1);
            bitslip = 1'b0;
            sampleLane(i);
        end
        checkOutput("verify biterr_cnt", 64'(biterr_cnt), 64'(1));
        checkOutput("verify biterr_beat", 64'(biterr_beat), 64'(15));
        checkOutput("verify lock_beat", 64'(lock_beat), 64'(47));
        checkOutput("locked pvalid_cnt", 64'(pvalid_cnt), 64'(4));
        checkOutput("locked bad_words", 64'(bad_words), 64'(0));

        // lock_i together with lock_rst_i: lane must stay in IDLE
        lock     = 1'b1;
        lock_rst = 1'b1;
        applyStimulus(4'h0, 1'b0);
        lock     = 1'b0;
        lock_rst = 1'b0;
        locked_cycles = 0;
        for (int i = 80; i < 120; i++) begin
            applyStimulus(streamNib(i, 0), 1'b1);
            if (locked[0]) locked_cycles++;
        end
        checkOutput("lock+lock_rst locked_cycles", 64'(locked_cycles), 64'(0));

        // async reset mid-word while LOCKED, then relock and capture
        resetDut();
        pulseLock();
        clearStats();
        for (int i = 0; i < 45; i++) begin
            if (i == 44) capture = 1'b1;
            applyStimulus(streamNib(i, 0), 1'b1);
            capture = 1'b0;
        end
        checkOutput("pre-reset locked", 64'(locked), 64'(1));
        checkOutput("pre-reset cap", 64'(cap), 64'(PAT));
        #2;
        aresetn   = 1'b0;
        cin_valid = 1'b0;
        #1;
        checkOutput("async reset locked", 64'(locked), 64'(0));
        checkOutput("async reset par", 64'(par), 64'(0));
        checkOutput("async reset cap", 64'(cap), 64'(0));
        step();
        step();
        aresetn = 1'b1;
        repeat (4) step();
        pulseLock();
        clearStats();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(streamNib(i, 0), 1'b1);
            sampleLane(i);
            if (i == 6) checkOutput("post-reset par@6", 64'(par), 64'(0));
            if (i == 7) checkOutput("post-reset par@7", 64'(par), 64'(PAT));
        end
        checkOutput("relock lock_beat", 64'(lock_beat), 64'(31));
        capture = 1'b1;
        applyStimulus(streamNib(40, 0), 1'b1);
        capture = 1'b0;
        checkOutput("relock cap", 64'(cap), 64'(PAT));

        // two lanes, lane 1 offset 5 nibbles, valid every other cycle
        aresetn2 = 1'b0;
        step();
        step();
        aresetn2 = 1'b1;
        repeat (4) step();
        lock2 = 1'b1;
        step();
        lock2 = 1'b0;
        for (int ln = 0; ln < 2; ln++) begin
            lockc[ln] = -1;
            pcnt[ln]  = 0;
            lastp[ln] = -1;
        end
        bad_gap     = 0;
        bad_word2   = 0;
        biterr2_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 2 == 0) begin
                valid2 = 1'b1;
                cin2   = {streamNib(c / 2, 5), streamNib(c / 2, 0)};
            end else begin
                valid2 = 1'b0;
                cin2   = 8'($urandom);
            end
            step();
            for (int ln = 0; ln < 2; ln++) begin
                if (locked2[ln] && lockc[ln] < 0) lockc[ln] = c;
                if (biterr2[ln]) biterr2_cnt++;
                if (pvalid2[ln]) begin
                    pcnt[ln]++;
                    if (lastp[ln] >= 0 && (c - lastp[ln]) != 16) bad_gap++;
                    lastp[ln] = c;
                    if (par2[ln*32 +: 32] !== PAT) bad_word2++;
                end
            end
        end
        valid2 = 1'b0;
        checkOutput("2lane lane0 lock_cycle", 64'(lockc[0]), 64'(62));
        checkOutput("2lane lane1 lock_cycle", 64'(lockc[1]), 64'(232));
        checkOutput("2lane lane0 words", 64'(pcnt[0]), 64'(33));
        checkOutput("2lane lane1 words", 64'(pcnt[1]), 64'(22));
        checkOutput("2lane bad_gap", 64'(bad_gap), 64'(0));
        checkOutput("2lane bad_words", 64'(bad_word2), 64'(0));
        checkOutput("2lane biterr_cnt", 64'(biterr2_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turfio_cin_parallel_lock.md
TURFIO_CIN_PARALLEL_LOCK -- requirements
Module: turfio_cin_parallel_lock

Interface
REQ-001 SHALL have parameter NLANE, default 1: number of independent CIN lanes.
REQ-002 SHALL have parameter INBITS, default 4: bits per lane per valid beat.
REQ-003 SHALL have parameter WORD_BITS, default 32: parallel word width; NBEATS = WORD_BITS/INBITS, which must be an integer of at least 2.
REQ-004 SHALL have parameter TRAIN_PATTERN, default 32'hA55A6996: training word, WORD_BITS wide.
REQ-005 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words required to declare lock (1..255).
REQ-006 SHALL have the following ports, one per line (name, direction, width, meaning):
  aclk_i  in  1  the only clock.
  aresetn_i  in  1  reset, asynchronous assert, active-low.
  cin_i  in  NLANE*INBITS  lane n occupies [n*INBITS +: INBITS].
  cin_valid_i  in  1  beat qualifier, common to all lanes.
  lock_i  in  1  single-cycle pulse: start automatic alignment on all lanes.
  lock_rst_i  in  1  single-cycle pulse: abort or unlock all lanes, return to IDLE.
  bitslip_i  in  NLANE  single-cycle pulse: manual word-phase slip per lane.
  capture_i  in  1  single-cycle pulse: snapshot all lanes' last completed words.
  locked_o  out  NLANE  lane is in LOCKED.
  lock_fail_o  out  NLANE  sticky flag: lane exhausted its slips.
  cin_biterr_o  out  NLANE  one-cycle pulse: training mismatch while in VERIFY.
  cin_parallel_o  out  NLANE*WORD_BITS  assembled words.
  cin_parallel_valid_o  out  NLANE  one-cycle word strobe per lane.
  capture_data_o  out  NLANE*WORD_BITS  snapshot register.

Function
REQ-007 Per lane, each cin_valid_i cycle SHALL shift the lane's INBITS into the LSBs of a WORD_BITS shift register; the first-received beat ends up in the MSBs.
REQ-008 Per lane, a beat counter SHALL run 0..NBEATS-1, wrap to 0, and advance only on cin_valid_i.
REQ-009 A word boundary SHALL occur on the cycle in which cin_valid_i is high and the beat counter equals NBEATS-1.
REQ-010 One cycle after a word boundary, the lane's word SHALL be registered onto cin_parallel_o.
REQ-011 cin_parallel_valid_o[n] SHALL pulse with that word only while lane n is LOCKED; cin_parallel_o SHALL update in all states.
REQ-012 A slip SHALL hold the beat counter for one valid beat, which delays the word boundary by one beat (INBITS bits); the shift register still shifts during that beat.
REQ-013 A slip request arriving while a previous slip is still pending SHALL be ignored.
REQ-014 Each lane SHALL run an FSM with states IDLE, HUNT, VERIFY, LOCKED, FAIL; the reset state is IDLE.
REQ-015 IDLE: bitslip_i[n] SHALL perform a slip. lock_i SHALL move the lane to HUNT and clear its slip counter, match counter and lock_fail.
REQ-016 HUNT, at each word boundary: a word equal to TRAIN_PATTERN SHALL move the lane to VERIFY with match count 1.
REQ-017 HUNT, at each word boundary: a mismatch SHALL increment the slip counter and perform a slip, then skip comparison for the following word (settling).
REQ-018 HUNT: when the slip counter reaches NBEATS without a match, the lane SHALL move to FAIL.
REQ-019 VERIFY, at each word boundary: a match SHALL increment the match count; when the count reaches LOCK_COUNT the lane SHALL move to LOCKED.
REQ-020 VERIFY, at each word boundary: a mismatch SHALL pulse cin_biterr_o[n] and return the lane to HUNT without slipping.
REQ-021 LOCKED: no pattern checking; bitslip_i[n] SHALL be ignored.
REQ-022 FAIL: lock_fail_o[n] SHALL be 1; only lock_i or lock_rst_i leaves FAIL.
REQ-023 lock_rst_i SHALL move every lane to IDLE from any state, and SHALL clear lock_fail_o.
REQ-024 lock_i and lock_rst_i asserted in the same cycle: lock_rst_i SHALL win.
REQ-025 lock_i asserted in HUNT, VERIFY or LOCKED SHALL restart HUNT.
REQ-026 A slip request coinciding with a word boundary SHALL apply from the next beat; the boundary word itself SHALL still be output.
REQ-027 capture_i SHALL load capture_data_o from the current cin_parallel_o on the next clock, irrespective of lane state.
REQ-028 Lanes SHALL be fully independent except for the shared cin_valid_i, lock_i, lock_rst_i and capture_i inputs.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 aresetn_i low SHALL asynchronously clear all FSMs to IDLE and clear all counters, shift registers, cin_parallel_o, capture_data_o and every flag/strobe output to 0; release SHALL be synchronous to aclk_i (deassertion synchronised internally).
REQ-031 Reset asserted mid-HUNT or mid-word SHALL discard the partial word; after release the first word boundary SHALL be the NBEATSth valid beat.

Verification
REQ-032 Defaults, cin_valid_i always 1, aligned 0xA55A6996 stream, lock_i pulse -> locked_o=1 after the 4th matching boundary; thereafter cin_parallel_valid_o pulses every 8 cycles with 0xA55A6996.
REQ-033 Pattern offset by 3 nibbles, lock_i -> exactly 3 slips, then VERIFY, then LOCKED; cin_biterr_o never pulses.
REQ-034 Constant-zero stream, lock_i -> lock_fail_o=1 after 8 slips and locked_o stays 0; a later lock_rst_i -> lock_fail_o=0 and lane in IDLE.
REQ-035 NLANE=2 with lane 1 offset 5 nibbles and cin_valid_i toggling every cycle -> both lanes lock independently; words delivered every 16 cycles.
REQ-036 In VERIFY, inject one corrupted word -> cin_biterr_o pulses once and the lane returns to HUNT; lock_i together with lock_rst_i -> IDLE.
REQ-037 aresetn_i pulsed low mid-word while LOCKED -> all outputs 0 immediately; capture_i after relock -> capture_data_o = 0xA55A6996.
